// File: rtl/hglobal_pkg.sv
// Shared constants for the handshake merge blocks: on/off levels, field
// widths, default debounce length and the arbiter FSM state encodings.
package hglobal;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam int unsigned NS_ADDRESS_SIZE = 4;
  localparam int unsigned NS_DATA_SIZE    = 8;
  localparam int unsigned NS_REDUN_SIZE   = 4;

  localparam int unsigned NS_REQ_CKS      = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_ACK_HI = 2'd2;

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/hdebouncer_req.sv
// Request debouncer: the cleaned level follows the raw request only after
// the raw level has been sampled at a new value for CKS consecutive cycles.
module hdebouncer_req
  import hglobal::*;
#(
  parameter int unsigned CKS = NS_REQ_CKS
) (
  input  logic gch_clk,
  input  logic gch_reset,
  input  logic i_req,
  output logic o_ckd_req,
  output logic o_rdy
);

  localparam int unsigned CW = cnt_width(CKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CKS - 1);

  logic          r_smp;
  logic          r_ckd;
  logic          r_rdy;
  logic [CW-1:0] r_cnt;

  // Sample the raw level, count consecutive differing samples, toggle when full.
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      r_smp <= NS_OFF;
      r_ckd <= NS_OFF;
      r_rdy <= NS_OFF;
      r_cnt <= '0;
    end else begin
      r_smp <= i_req;
      r_rdy <= NS_ON;
      if (r_smp == r_ckd) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_ckd <= r_smp;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_ckd_req = r_ckd;
  assign o_rdy     = r_rdy;

endmodule

// File: rtl/hround_robin_merge.sv
// Two-input four-phase handshake merge with round-robin arbitration.
// Each input request is debounced; the winner's message is registered onto
// the single output channel and its acknowledge is returned once the
// downstream consumer has acknowledged.
module hround_robin_merge
  import hglobal::*;
#(
  parameter int unsigned ASZ         = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ         = NS_DATA_SIZE,
  parameter int unsigned RSZ         = NS_REDUN_SIZE,
  parameter int unsigned RCV_REQ_CKS = NS_REQ_CKS
) (
  input  logic                   gch_clk,
  input  logic                   gch_reset,
  output logic                   gch_ready,

  input  logic                   rcv0_req,
  output logic                   rcv0_ack,
  input  logic [ASZ+DSZ+RSZ-1:0] rcv0_data,

  input  logic                   rcv1_req,
  output logic                   rcv1_ack,
  input  logic [ASZ+DSZ+RSZ-1:0] rcv1_data,

  output logic                   snd0_req,
  input  logic                   snd0_ack,
  output logic [ASZ+DSZ+RSZ-1:0] snd0_data
);

  localparam int unsigned MSZ = ASZ + DSZ + RSZ;

  logic [1:0]     w_ckd;
  logic [1:0]     w_rdy;
  logic           w_win;
  logic           w_win_ckd;

  logic [1:0]     r_state;
  logic           rg_rdy;
  logic           rg_pri;
  logic           r_win;
  logic           r_snd_req;
  logic [1:0]     r_ack;
  logic [MSZ-1:0] r_snd_data;

  hdebouncer_req #(.CKS(RCV_REQ_CKS)) u_deb0 (
    .gch_clk   (gch_clk),
    .gch_reset (gch_reset),
    .i_req     (rcv0_req),
    .o_ckd_req (w_ckd[0]),
    .o_rdy     (w_rdy[0])
  );

  hdebouncer_req #(.CKS(RCV_REQ_CKS)) u_deb1 (
    .gch_clk   (gch_clk),
    .gch_reset (gch_reset),
    .i_req     (rcv1_req),
    .o_ckd_req (w_ckd[1]),
    .o_rdy     (w_rdy[1])
  );

  // Arbitration: a lone requester wins; on a tie the priority pointer decides.
  always_comb begin
    w_win     = (w_ckd[0] && w_ckd[1]) ? rg_pri : w_ckd[1];
    w_win_ckd = r_win ? w_ckd[1] : w_ckd[0];
  end

  // Block-level ready flag, set on the first edge after reset release.
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      rg_rdy <= NS_OFF;
    end else begin
      rg_rdy <= NS_ON;
    end
  end

  // Transfer FSM: grant and latch, wait for downstream ack, then wait for
  // the winner to release its request before handing priority over.
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      r_state    <= ST_IDLE;
      rg_pri     <= NS_OFF;
      r_win      <= NS_OFF;
      r_snd_req  <= NS_OFF;
      r_ack      <= '0;
      r_snd_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rg_rdy && (w_ckd[0] || w_ckd[1])) begin
            r_win      <= w_win;
            r_snd_data <= w_win ? rcv1_data : rcv0_data;
            r_snd_req  <= NS_ON;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (snd0_ack) begin
            r_snd_req    <= NS_OFF;
            r_ack[r_win] <= NS_ON;
            r_state      <= ST_ACK_HI;
          end
        end
        ST_ACK_HI: begin
          if (!w_win_ckd && !snd0_ack) begin
            r_ack   <= '0;
            rg_pri  <= ~r_win;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_snd_req <= NS_OFF;
          r_ack     <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Only one input may ever be acknowledged at a time.
  a_one_ack : assert property (@(posedge gch_clk) disable iff (!gch_reset)
                               !(r_ack[0] && r_ack[1]));

  assign gch_ready = rg_rdy & w_rdy[0] & w_rdy[1];
  assign snd0_req  = r_snd_req;
  assign snd0_data = r_snd_data;
  assign rcv0_ack  = r_ack[0];
  assign rcv1_ack  = r_ack[1];

endmodule
